// File: rtl/instruction_fetch_unit.sv
// Byte-serial instruction fetch: assembles four big-endian bytes per instruction and hands them to decode via valid/ready.
// Optional IFU_ALIGN_CHECK_EN rejects misaligned redirects and raises a sticky misalign flag.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] instruction,
  output logic [31:0] ins_pc,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_d;
  logic [31:0] pc;
  logic [2:0]  cnt;
  logic        redir_take;
  logic [31:0] redir_tgt;
  logic        handshake;
  logic        capture;
  logic        last_byte;

`ifdef IFU_ALIGN_CHECK_EN
  logic redir_bad;
  assign redir_bad  = redirect & (state != IDLE) & (|redirect_pc[1:0]);
  assign redir_take = redirect & (state != IDLE) & ~(|redirect_pc[1:0]);
  assign redir_tgt  = redirect_pc;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          misalign <= 1'b0;
    else if (redir_bad) misalign <= 1'b1;
  end
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign redir_take = redirect & (state != IDLE);
  assign redir_tgt  = {redirect_pc[31:2], 2'b00};
  assign misalign   = 1'b0;
`endif

  // ins_valid is only ever set in HOLD, so no state qualifier is needed here
  assign handshake = ins_valid & ins_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    capture   = 1'b0;
    last_byte = 1'b0;
    case (state)
      IDLE:  state_d = FETCH;
      FETCH: begin
        mem_req  = (cnt < 3'd4);
        mem_addr = pc + {29'b0, cnt};
        // byte requested at cnt-1 arrives one cycle later
        capture  = (cnt != 3'd0);
        if (cnt == 3'd4) begin
          last_byte = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD:    if (handshake) state_d = FETCH;
      default: state_d = IDLE;
    endcase
    if (redir_take) state_d = FETCH;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc          <= RESET_PC;
      cnt         <= 3'd0;
      ins_valid   <= 1'b0;
      instruction <= 32'h0;
      ins_pc      <= 32'h0;
    end else if (redir_take) begin
      // restart from target; partial word and in-flight byte are dropped
      pc        <= redir_tgt;
      cnt       <= 3'd0;
      ins_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (capture) begin
            case (cnt)
              3'd1:    instruction[31:24] <= mem_rdata;
              3'd2:    instruction[23:16] <= mem_rdata;
              3'd3:    instruction[15:8]  <= mem_rdata;
              default: instruction[7:0]   <= mem_rdata;
            endcase
          end
          if (last_byte) begin
            ins_valid <= 1'b1;
            ins_pc    <= pc;
            cnt       <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        HOLD: begin
          if (handshake) begin
            pc        <= pc + 32'd4;
            ins_valid <= 1'b0;
          end
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a timing-level reference model predicts bus activity and delivered words.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] instruction;
  logic [31:0] ins_pc;
  logic        misalign;

  instruction_fetch_unit dut (
    .CLK(CLK), .RESET(RESET),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .instruction(instruction), .ins_pc(ins_pc), .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  // byte memory aliased on the low 8 address bits, 1-cycle read
  logic [7:0] mem [256];
  always @(posedge CLK) mem_rdata <= mem[mem_addr[7:0]];

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t        q[$];
  bit          m_started, m_valid, m_mis;
  int          m_timer;
  logic [31:0] m_pc;
  int          n_vec, n_err;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] b, w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b = a + 32'(i);
      w = {w[23:0], mem[b[7:0]]};
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch started at edge 0 delivers its word at edge 5;
  // words are consumed on valid&ready, redirects restart from the target.
  task automatic model_step();
    bit rd_ok;
    if (RESET) begin
      m_started = 0; m_valid = 0; m_timer = 0; m_pc = 32'h0; m_mis = 0;
      q.delete();
    end else if (!m_started) begin
      m_started = 1; m_timer = 0;
    end else begin
`ifdef IFU_ALIGN_CHECK_EN
      rd_ok = redirect && (redirect_pc[1:0] == 2'b00);
      if (redirect && !rd_ok) m_mis = 1;
`else
      rd_ok = redirect;
`endif
      if (rd_ok) begin
        if (m_valid && !ins_ready) void'(q.pop_back());
        m_pc = redirect_pc & ~32'h3;
        m_timer = 0; m_valid = 0;
      end else if (m_valid) begin
        if (ins_ready) begin
          m_pc = m_pc + 32'd4; m_valid = 0; m_timer = 0;
        end
      end else begin
        m_timer++;
        if (m_timer == 5) begin
          m_valid = 1;
          q.push_back('{m_pc, ref_word(m_pc)});
        end
      end
    end
  endtask

  initial forever begin
    @(posedge CLK or posedge RESET);
    model_step();
  end

  // monitor: compares DUT outputs against model/scoreboard mid-cycle
  initial forever begin
    @(negedge CLK);
    if (!RESET) begin
      bit exp_req;
      exp_req = m_started && !m_valid && (m_timer < 4);
      chk("ins_valid", {31'b0, ins_valid}, {31'b0, m_valid});
      chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      if (exp_req) chk("mem_addr", mem_addr, m_pc + 32'(m_timer));
      chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
      if (m_valid) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL scoreboard: no expected word while valid at %0t", $time);
        end else begin
          if (ins_valid) begin
            chk("ins_pc", ins_pc, q[0].pc);
            chk("instruction", instruction, q[0].ins);
          end
          if (ins_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc);
    @(posedge CLK); #1;
    ins_ready = r; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; redirect = 1'b0;
    #1;
    chk("rst ins_valid", {31'b0, ins_valid}, 32'h0);
    chk("rst mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst ins_pc", ins_pc, 32'h0);
    chk("rst instruction", instruction, 32'h0);
    chk("rst misalign", {31'b0, misalign}, 32'h0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic wait_model(input bit want_valid, input int want_timer, input logic r, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      cyc(r, 1'b0, 32'h0);
      hit = m_started && (want_valid ? m_valid : (!m_valid && m_timer == want_timer));
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL timeout %s: condition not reached within 30 cycles", name);
    end
  endtask

  initial begin
    RESET = 1'b0; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h10; mem[3] = 8'h20;

    // basic stream, first word 32'h00011020 at pc 0
    do_reset();
    repeat (16) cyc(1'b1, 1'b0, 32'h0);

    // decode stalled, then released
    do_reset();
    repeat (20) cyc(1'b0, 1'b0, 32'h0);
    repeat (8)  cyc(1'b1, 1'b0, 32'h0);

    // redirect to 0x30 mid-fetch (cnt=2)
    do_reset();
    wait_model(1'b0, 2, 1'b1, "cnt2");
    cyc(1'b1, 1'b1, 32'h30);
    repeat (10) cyc(1'b1, 1'b0, 32'h0);

    // redirect coincident with handshake
    cyc(1'b0, 1'b1, 32'h24);
    wait_model(1'b1, 0, 1'b0, "valid24");
    cyc(1'b1, 1'b1, 32'h28);
    wait_model(1'b1, 0, 1'b0, "valid28");
    cyc(1'b1, 1'b1, 32'h40);
    repeat (10) cyc(1'b1, 1'b0, 32'h0);

    // address wrap past 2^32
    cyc(1'b1, 1'b1, 32'hFFFFFFFC);
    repeat (16) cyc(1'b1, 1'b0, 32'h0);

    // misaligned redirect
    cyc(1'b1, 1'b1, 32'h31);
    repeat (10) cyc(1'b1, 1'b0, 32'h0);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 255)));
    end
    repeat (2) cyc(1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
